// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// word geometry, response error codes and the access-legality check.
// No ports (package).
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int   WORD_BYTES = 4;

   localparam logic RSP_ERR = 1'b1;
   localparam logic RSP_OK  = 1'b0;

   // An access is illegal when it is not word aligned or when its word index
   // falls beyond the end of the array.
   function automatic logic access_err(input logic [31:0] addr,
                                       input int unsigned depth);
      logic bad;
      bad = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
      return bad ? RSP_ERR : RSP_OK;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit storage with per-byte write enables. Writes land on the
// rising clock edge; reads are combinational from the same address port.
// Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write enable (qualified per byte by wstrb)
//   wstrb  in   byte enables, bit i -> wdata[8i+7:8i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data at addr
// ---------------------------------------------------------------------------
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [3:0]               wstrb,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (wstrb[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the core's data-memory port. Accepts one
// load/store at a time over a valid/ready request channel, waits LATENCY
// cycles, performs the word access, then presents the result on a
// valid/ready response channel until it is taken.
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_wstrb  in   store byte enables
//   rsp_valid  out  response present
//   rsp_ready  in   requester takes the response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  misaligned or out-of-range access
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         AW       = $clog2(DEPTH);
   // The counter is loaded with LATENCY-1 so that the access happens on the
   // LATENCY-th edge after acceptance.
   localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;

   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_wstrb;

   logic        accept;
   logic        do_access;
   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_wstrb;
   logic        acc_err;
   logic        arr_we;
   logic [31:0] arr_rdata;

   assign accept = (state == IDLE) && req_valid;

   // With zero latency the access happens on the acceptance edge itself, so
   // the live request fields feed the array; otherwise the latched copy does.
   always_comb begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
      if (state == IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end
   end

   always_comb begin
      do_access = 1'b0;
      if (LATENCY == 0) begin
         do_access = accept;
      end else begin
         do_access = (state == WAIT) && (cnt == 4'd0);
      end
   end

   assign acc_err = access_err(acc_addr, DEPTH);
   assign arr_we  = do_access && acc_we && !acc_err;

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .wstrb (acc_wstrb),
      .addr  (acc_addr[AW+1:2]),
      .wdata (acc_wdata),
      .rdata (arr_rdata)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; both outputs decode registered state
   // only, so no request or response input reaches them combinationally.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = (LATENCY == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Wait counter and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= RSP_OK;
      end else begin
         if (accept) begin
            cnt <= CNT_INIT;
         end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (do_access) begin
            rsp_rdata <= (acc_we || acc_err) ? 32'd0 : arr_rdata;
            rsp_err   <= acc_err;
         end
      end
   end

   // Request capture; pure data, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_wstrb <= req_wstrb;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;

   // Instance A: LATENCY = 2
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   // Instance B: LATENCY = 0
   logic        b_req_valid, b_req_ready, b_req_we;
   logic [31:0] b_req_addr, b_req_wdata;
   logic [3:0]  b_req_wstrb;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .LATENCY(2)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   dmem_responder #(.DEPTH(64), .LATENCY(0)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .req_we    (b_req_we),
      .req_addr  (b_req_addr),
      .req_wdata (b_req_wdata),
      .req_wstrb (b_req_wstrb),
      .rsp_valid (b_rsp_valid),
      .rsp_ready (b_rsp_ready),
      .rsp_rdata (b_rsp_rdata),
      .rsp_err   (b_rsp_err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request on instance A (called just after a clock edge with
   // req_ready high), scramble the request inputs after acceptance, wait for
   // the response and take it. lat counts cycles from acceptance edge to the
   // first rsp_valid cycle.
   task automatic xact(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic err,
                       output int lat);
      int cyc;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = ~wdata;
      req_wstrb = 4'hF;
      cyc = 1;
      while (!rsp_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      lat   = cyc;
      rdata = rsp_rdata;
      err   = rsp_err;
      if (rsp_valid) begin
         @(posedge clk); #1;
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          cyc;

   initial begin
      reset       = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_addr    = 32'd0;
      req_wdata   = 32'd0;
      req_wstrb   = 4'd0;
      rsp_ready   = 1'b1;
      b_req_valid = 1'b0;
      b_req_we    = 1'b0;
      b_req_addr  = 32'd0;
      b_req_wdata = 32'd0;
      b_req_wstrb = 4'd0;
      b_rsp_ready = 1'b1;

      #12;
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("rst_req_ready", 32'(req_ready), 32'd1);
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
      check_val("rst_rsp_err",   32'(rsp_err), 32'd0);

      // full-word store then load
      xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      check_val("st_latency", 32'(lat), 32'd3);
      check_val("st_rdata",   rd, 32'd0);
      check_val("st_err",     32'(er), 32'd0);
      check_val("idle_after_rsp", 32'(req_ready), 32'd1);
      xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check_val("ld_latency", 32'(lat), 32'd3);
      check_val("ld_full",    rd, 32'hDEADBEEF);
      check_val("ld_full_err", 32'(er), 32'd0);

      // byte-0 store
      xact(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
      xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check_val("ld_byte0", rd, 32'hDEADBEAA);

      // zero-strobe store is a no-op
      xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
      check_val("st_nostrb_err", 32'(er), 32'd0);
      xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check_val("ld_after_nostrb", rd, 32'hDEADBEAA);

      // prepare word 0x20 = 0
      xact(1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat);

      // error accesses
      xact(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
      check_val("mis_err",   32'(er), 32'd1);
      check_val("mis_rdata", rd, 32'd0);
      xact(1'b0, 32'h100, 32'h0, 4'h0, rd, er, lat);
      check_val("oor_err",   32'(er), 32'd1);
      check_val("oor_rdata", rd, 32'd0);
      xact(1'b1, 32'h11, 32'h55555555, 4'hF, rd, er, lat);
      check_val("mis_st_err", 32'(er), 32'd1);
      check_val("mis_st_rdata", rd, 32'd0);
      xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check_val("ld_after_err", rd, 32'hDEADBEAA);
      check_val("ld_after_err_e", 32'(er), 32'd0);

      // response held for 5 cycles
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = 32'h20;
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_val("hold_arrive", 32'(cyc), 32'd2);
      for (int i = 0; i < 5; i++) begin
         check_val("hold_valid", 32'(rsp_valid), 32'd1);
         check_val("hold_rdata", rsp_rdata, 32'hDEADBEAA);
         check_val("hold_err",   32'(rsp_err), 32'd0);
         check_val("hold_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      check_val("ack_cycle_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check_val("post_ack_valid", 32'(rsp_valid), 32'd0);
      check_val("post_ack_req_ready", 32'(req_ready), 32'd1);

      // reset while a store waits
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      req_wstrb = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val("wait_req_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      #1;
      check_val("async_rst_req_ready", 32'(req_ready), 32'd1);
      check_val("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      #2;
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("rel_req_ready", 32'(req_ready), 32'd1);
      check_val("rel_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check_val("rel_rsp_valid2", 32'(rsp_valid), 32'd0);
      xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      check_val("ld_after_rst", rd, 32'h0);

      // mixed byte strobes
      xact(1'b1, 32'h20, 32'h11223344, 4'b1010, rd, er, lat);
      xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      check_val("ld_strb1010", rd, 32'h11003300);

      // highest legal word
      xact(1'b1, 32'hFC, 32'hA5A5_5A5A, 4'hF, rd, er, lat);
      check_val("top_st_err", 32'(er), 32'd0);
      xact(1'b0, 32'hFC, 32'h0, 4'h0, rd, er, lat);
      check_val("top_ld", rd, 32'hA5A5_5A5A);

      // zero-latency instance
      @(posedge clk); #1;
      b_rsp_ready = 1'b0;
      b_req_valid = 1'b1;
      b_req_we    = 1'b1;
      b_req_addr  = 32'h4;
      b_req_wdata = 32'hCAFEF00D;
      b_req_wstrb = 4'hF;
      @(posedge clk); #1;
      check_val("b_lat0_valid", 32'(b_rsp_valid), 32'd1);
      check_val("b_st_err",     32'(b_rsp_err), 32'd0);
      b_req_we   = 1'b0;
      b_req_addr = 32'h4;
      check_val("b_busy_req_ready", 32'(b_req_ready), 32'd0);
      @(posedge clk); #1;
      check_val("b_hold_valid", 32'(b_rsp_valid), 32'd1);
      check_val("b_hold_rdata", b_rsp_rdata, 32'd0);
      b_rsp_ready = 1'b1;
      @(posedge clk); #1;
      check_val("b_idle_req_ready", 32'(b_req_ready), 32'd1);
      check_val("b_idle_rsp_valid", 32'(b_rsp_valid), 32'd0);
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      check_val("b_ld_valid", 32'(b_rsp_valid), 32'd1);
      check_val("b_ld_rdata", b_rsp_rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
      check_val("b_done_valid", 32'(b_rsp_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
